// File: rtl/regfile_wb_queue.sv
// rtl/regfile_wb_queue.sv - writeback queue feeding the register file write port
//
// Purpose: accepts register write requests from the load unit and the ALU
// (load has fixed priority), buffers them in a DEPTH-entry FIFO and drains at
// most one entry per cycle onto the register file write port. It also reports
// whether a queried register still has a write in flight.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   ld_valid/ld_ready         load unit handshake; ld_addr, ld_data, ld_lane
//   alu_valid/alu_ready       ALU handshake; alu_addr, alu_data, alu_lane
//   Rd_addr, Rd_in            register file write address / data (registered)
//   Rd_Byte_w_en              register file write enables, active-low per bit
//   chk_addr, chk_pending     hazard query (combinational)
//   count                     FIFO occupancy, output register excluded

module regfile_wb_queue #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 2,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ld_valid,
    output logic                         ld_ready,
    input  logic [ADDR_WIDTH-1:0]        ld_addr,
    input  logic [DATA_WIDTH-1:0]        ld_data,
    input  logic [DATA_WIDTH-1:0]        ld_lane,
    input  logic                         alu_valid,
    output logic                         alu_ready,
    input  logic [ADDR_WIDTH-1:0]        alu_addr,
    input  logic [DATA_WIDTH-1:0]        alu_data,
    input  logic [DATA_WIDTH-1:0]        alu_lane,
    output logic [ADDR_WIDTH-1:0]        Rd_addr,
    output logic [DATA_WIDTH-1:0]        Rd_in,
    output logic [DATA_WIDTH-1:0]        Rd_Byte_w_en,
    input  logic [ADDR_WIDTH-1:0]        chk_addr,
    output logic                         chk_pending,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0] r_mem_addr [DEPTH];
    logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
    logic [DATA_WIDTH-1:0] r_mem_lane [DEPTH];

    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;

    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [DATA_WIDTH-1:0] r_rd_in;
    logic [DATA_WIDTH-1:0] r_rd_en_n;

    logic                  w_space;
    logic                  w_ld_fire;
    logic                  w_alu_fire;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [DATA_WIDTH-1:0] w_sel_lane;
    logic                  w_push;
    logic                  w_pop;
    logic [DEPTH-1:0]      w_hit;
    logic                  w_out_hit;

    // Readiness uses the occupancy before this cycle's pop, so a full queue
    // never passes a request straight through. Reset blocks every handshake.
    assign w_space    = (r_count < CW'(DEPTH));
    assign ld_ready   = !rst && w_space;
    assign alu_ready  = !rst && w_space && !ld_valid;

    assign w_ld_fire  = ld_valid && ld_ready;
    assign w_alu_fire = alu_valid && alu_ready;

    assign w_sel_addr = w_ld_fire ? ld_addr : alu_addr;
    assign w_sel_data = w_ld_fire ? ld_data : alu_data;
    assign w_sel_lane = w_ld_fire ? ld_lane : alu_lane;

    // Writes to register 0 or with no lanes set are acknowledged but dropped:
    // they would have no effect on the register file.
    assign w_push = (w_ld_fire || w_alu_fire)
                    && (w_sel_addr != '0) && (w_sel_lane != '0);
    assign w_pop  = (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= w_sel_addr;
            r_mem_data[r_wr_ptr] <= w_sel_data;
            r_mem_lane[r_wr_ptr] <= w_sel_lane;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_rd_addr <= '0;
            r_rd_in   <= '0;
            r_rd_en_n <= '1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_addr <= r_mem_addr[r_rd_ptr];
                r_rd_in   <= r_mem_data[r_rd_ptr];
                r_rd_en_n <= ~r_mem_lane[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + 1'b1;
            end else begin
                r_rd_addr <= '0;
                r_rd_in   <= '0;
                r_rd_en_n <= '1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // An entry is live when its distance from the read pointer (mod DEPTH)
    // is below the occupancy.
    for (genvar g = 0; g < DEPTH; g++) begin : g_hit
        logic [PW-1:0] w_off;
        assign w_off    = PW'(g) - r_rd_ptr;
        assign w_hit[g] = ({1'b0, w_off} < r_count) && (r_mem_addr[g] == chk_addr);
    end

    assign w_out_hit   = (r_rd_en_n != '1) && (r_rd_addr == chk_addr);
    assign chk_pending = (chk_addr != '0) && ((|w_hit) || w_out_hit);

    assign Rd_addr      = r_rd_addr;
    assign Rd_in        = r_rd_in;
    assign Rd_Byte_w_en = r_rd_en_n;
    assign count        = r_count;

endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb/tb_regfile_wb_queue.sv - scoreboard bench for regfile_wb_queue
module tb_regfile_wb_queue;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ld_valid = 1'b0;
    logic       ld_ready;
    logic [1:0] ld_addr = '0;
    logic [3:0] ld_data = '0;
    logic [3:0] ld_lane = '0;
    logic       alu_valid = 1'b0;
    logic       alu_ready;
    logic [1:0] alu_addr = '0;
    logic [3:0] alu_data = '0;
    logic [3:0] alu_lane = '0;
    logic [1:0] Rd_addr;
    logic [3:0] Rd_in;
    logic [3:0] Rd_Byte_w_en;
    logic [1:0] chk_addr = '0;
    logic       chk_pending;
    logic [2:0] count;

    int n_cmp = 0;
    int n_bad = 0;
    logic [9:0] sb_q[$];

    regfile_wb_queue #(.DATA_WIDTH(4), .ADDR_WIDTH(2), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_lane(ld_lane),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr),
        .alu_data(alu_data), .alu_lane(alu_lane),
        .Rd_addr(Rd_addr), .Rd_in(Rd_in), .Rd_Byte_w_en(Rd_Byte_w_en),
        .chk_addr(chk_addr), .chk_pending(chk_pending), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every register-file write must match the next expected entry;
    // idle cycles must present the zero address and data.
    initial begin
        forever begin
            @(negedge clk);
            if (Rd_Byte_w_en !== 4'hF) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: got %0h expected none",
                             {Rd_addr, Rd_in, Rd_Byte_w_en});
                end else begin
                    chk("rd_write", {22'd0, Rd_addr, Rd_in, Rd_Byte_w_en}, {22'd0, sb_q.pop_front()});
                end
            end else begin
                chk("idle_value", {26'd0, Rd_addr, Rd_in}, 32'd0);
            end
        end
    end

    // One load request held for one cycle; exp is {addr, data, en_n} or
    // ignored when the request is expected to be filtered.
    task automatic cyc_ld(input logic [1:0] a, input logic [3:0] d, input logic [3:0] l,
                          input logic [9:0] exp, input bit store);
        ld_valid = 1'b1; ld_addr = a; ld_data = d; ld_lane = l;
        @(negedge clk);
        chk("ld_ready", ld_ready, 1);
        chk("count_le_depth", count <= 3'd4, 1);
        if (store) sb_q.push_back(exp);
        @(posedge clk); #1;
        ld_valid = 1'b0;
    endtask

    task automatic cyc_alu(input logic [1:0] a, input logic [3:0] d, input logic [3:0] l,
                           input logic [9:0] exp, input bit store);
        alu_valid = 1'b1; alu_addr = a; alu_data = d; alu_lane = l;
        @(negedge clk);
        chk("alu_ready", alu_ready, 1);
        if (store) sb_q.push_back(exp);
        @(posedge clk); #1;
        alu_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    logic [1:0] f_addr [8] = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2};
    logic [3:0] f_data [8] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
    logic [3:0] f_lane [8] = '{4'hF, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'h9};
    logic [3:0] f_en   [8] = '{4'h0, 4'hE, 4'hD, 4'hB, 4'h7, 4'hC, 4'h3, 4'h6};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for two edges
        @(negedge clk);
        chk("rst_en", Rd_Byte_w_en, 4'hF);
        chk("rst_count", count, 0);
        chk("rst_pending", chk_pending, 0);
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_alu_ready", alu_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ld_ready", ld_ready, 1);
        chk("idle_alu_ready", alu_ready, 1);
        chk("idle_count", count, 0);
        chk("idle_addr", Rd_addr, 0);
        @(posedge clk); #1;

        // Single write: addr 2, data A, lanes 0110 -> enables 1001
        cyc_ld(2'd2, 4'hA, 4'b0110, {2'd2, 4'hA, 4'b1001}, 1'b1);
        @(negedge clk);
        chk("single_count", count, 1);
        idle(2);
        @(negedge clk);
        chk("single_after_idle", Rd_Byte_w_en, 4'hF);
        idle(1);

        // Contention: load wins for three cycles, ALU goes on the fourth
        alu_valid = 1'b1; alu_addr = 2'd1; alu_data = 4'h5; alu_lane = 4'hF;
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1; ld_addr = 2'd3; ld_data = 4'(i + 9); ld_lane = 4'h3;
            @(negedge clk);
            chk("cont_ld_ready", ld_ready, 1);
            chk("cont_alu_ready", alu_ready, 0);
            sb_q.push_back({2'd3, 4'(i + 9), 4'hC});
            @(posedge clk); #1;
        end
        ld_valid = 1'b0;
        @(negedge clk);
        chk("cont_alu_ready_free", alu_ready, 1);
        sb_q.push_back({2'd1, 4'h5, 4'h0});
        @(posedge clk); #1;
        alu_valid = 1'b0;
        idle(3);

        // Back-to-back stream of 2*DEPTH writes across pointer wrap
        for (int i = 0; i < 8; i++)
            cyc_ld(f_addr[i], f_data[i], f_lane[i], {f_addr[i], f_data[i], f_en[i]}, 1'b1);
        @(negedge clk);
        chk("stream_count", count, 1);
        idle(3);

        // Filtering: addr 0 from ALU and lane 0 from load are dropped
        cyc_alu(2'd0, 4'h7, 4'hF, '0, 1'b0);
        @(negedge clk);
        chk("filter_addr0_count", count, 0);
        idle(1);
        cyc_ld(2'd2, 4'h5, 4'h0, '0, 1'b0);
        @(negedge clk);
        chk("filter_lane0_count", count, 0);
        idle(2);

        // Hazard tracking on register 3
        chk_addr = 2'd3;
        @(negedge clk);
        chk("haz_before", chk_pending, 0);
        @(posedge clk); #1;
        cyc_ld(2'd3, 4'h6, 4'hF, {2'd3, 4'h6, 4'h0}, 1'b1);
        @(negedge clk);
        chk("haz_in_fifo", chk_pending, 1);
        chk_addr = 2'd2;
        #1;
        chk("haz_other_addr", chk_pending, 0);
        chk_addr = 2'd3;
        @(posedge clk); #1;
        @(negedge clk);
        chk("haz_in_output", chk_pending, 1);
        chk_addr = 2'd0;
        #1;
        chk("haz_addr0", chk_pending, 0);
        chk_addr = 2'd3;
        @(posedge clk); #1;
        @(negedge clk);
        chk("haz_cleared", chk_pending, 0);
        idle(2);

        // Mid-operation reset: A and B drain before the reset edge, C is lost
        cyc_ld(2'd1, 4'h1, 4'h1, {2'd1, 4'h1, 4'hE}, 1'b1);
        cyc_ld(2'd2, 4'h2, 4'h2, {2'd2, 4'h2, 4'hD}, 1'b1);
        cyc_ld(2'd3, 4'h3, 4'h4, '0, 1'b0);
        rst = 1'b1;
        ld_valid = 1'b1; ld_addr = 2'd1; ld_data = 4'hF; ld_lane = 4'hF;
        @(negedge clk);
        chk("mrst_ld_ready", ld_ready, 0);
        chk("mrst_alu_ready", alu_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        ld_valid = 1'b0;
        @(negedge clk);
        chk("mrst_count", count, 0);
        chk("mrst_en", Rd_Byte_w_en, 4'hF);
        chk("mrst_pending", chk_pending, 0);
        idle(4);

        @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
